// File: rtl/pulse_capture_sequencer_pkg.sv
// Shared definitions for the per-pulse capture sequencer: state encoding,
// metadata field placement and the metadata word count.
package pulse_capture_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_DELAY   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // Metadata fields, LSB first; the packer shifts out from bit 0.
   localparam int AZ_W            = 16;
   localparam int TICK_W          = 32;
   localparam int TRIG_W          = 32;
   localparam int MISSED_W        = 16;
   localparam int META_ARP_LSB    = 0;
   localparam int META_ACP_LSB    = META_ARP_LSB + AZ_W;
   localparam int META_TICK_LSB   = META_ACP_LSB + AZ_W;
   localparam int META_TRIG_LSB   = META_TICK_LSB + TICK_W;
   localparam int META_MISSED_LSB = META_TRIG_LSB + TRIG_W;
   localparam int META_USED_W     = META_MISSED_LSB + MISSED_W;

   // Number of packer samples needed to ship the whole metadata word.
   function automatic int meta_words(input int meta_w, input int pack_w);
      return (meta_w + pack_w - 1) / pack_w;
   endfunction

endpackage

// File: rtl/pulse_capture_sequencer_azimuth_counter.sv
// Azimuth pulse counters: acp counts within a revolution, arp counts
// revolutions and restarts acp; arp wins when both edges coincide.
module azimuth_counter
   import pulse_capture_sequencer_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            acp,
   input  logic            arp,
   output logic [AZ_W-1:0] acp_count,
   output logic [AZ_W-1:0] arp_count
);

   logic            acp_prev_q, acp_prev_d;
   logic            arp_prev_q, arp_prev_d;
   logic [AZ_W-1:0] acp_cnt_q, acp_cnt_d;
   logic [AZ_W-1:0] arp_cnt_q, arp_cnt_d;
   logic            acp_edge;
   logic            arp_edge;

   always_comb begin
      acp_edge   = acp & ~acp_prev_q;
      arp_edge   = arp & ~arp_prev_q;
      acp_prev_d = acp;
      arp_prev_d = arp;
      acp_cnt_d  = acp_cnt_q;
      arp_cnt_d  = arp_cnt_q;
      if (arp_edge) begin
         arp_cnt_d = arp_cnt_q + AZ_W'(1);
         acp_cnt_d = '0;
      end else if (acp_edge) begin
         acp_cnt_d = acp_cnt_q + AZ_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acp_prev_q <= 1'b0;
         arp_prev_q <= 1'b0;
         acp_cnt_q  <= '0;
         arp_cnt_q  <= '0;
      end else begin
         acp_prev_q <= acp_prev_d;
         arp_prev_q <= arp_prev_d;
         acp_cnt_q  <= acp_cnt_d;
         arp_cnt_q  <= arp_cnt_d;
      end
   end

   assign acp_count = acp_cnt_q;
   assign arp_count = arp_cnt_q;

endmodule

// File: rtl/pulse_capture_sequencer.sv
// Per-pulse sequencer for the metadata packer: snapshots counters on an
// accepted trigger, skips pre_delay strobes, then enables the packer.
//
//   state   | meaning
//   IDLE    | waiting for a trigger edge with run=1
//   ARM     | one cycle, pack_init high, strobes ignored
//   DELAY   | counting down pre_delay strobes, packer not enabled
//   CAPTURE | pack_enable high, counting down the effective sample count
//   DONE    | one cycle, pulse_done high
module pulse_capture_sequencer
   import pulse_capture_sequencer_pkg::*;
#(
   parameter int META_WIDTH = 112,
   parameter int PACK_WIDTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  trigger,
   input  logic                  acp,
   input  logic                  arp,
   input  logic                  strobe_in,
   input  logic [CNT_WIDTH-1:0]  pre_delay,
   input  logic [CNT_WIDTH-1:0]  n_samples,
   output logic [META_WIDTH-1:0] meta_data,
   output logic                  pack_init,
   output logic                  pack_enable,
   output logic                  busy,
   output logic                  pulse_done
);

   localparam int                   META_WORDS   = meta_words(META_WIDTH, PACK_WIDTH);
   localparam logic [CNT_WIDTH-1:0] META_WORDS_C = CNT_WIDTH'(META_WORDS);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
   localparam logic [MISSED_W-1:0]  MISSED_MAX   = '1;

   state_e                state_q, state_d;
   logic                  trig_prev_q, trig_prev_d;
   logic [TICK_W-1:0]     tick_q, tick_d;
   logic [TRIG_W-1:0]     trig_cnt_q, trig_cnt_d;
   logic [MISSED_W-1:0]   missed_q, missed_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]  pre_q, pre_d;
   logic [CNT_WIDTH-1:0]  eff_q, eff_d;
   logic [META_WIDTH-1:0] meta_q, meta_d;

   logic [AZ_W-1:0]       acp_count;
   logic [AZ_W-1:0]       arp_count;
   logic [META_WIDTH-1:0] meta_snap;
   logic                  trig_edge;
   logic                  accept;

   azimuth_counter u_azimuth (
      .clock     (clock),
      .reset     (reset),
      .acp       (acp),
      .arp       (arp),
      .acp_count (acp_count),
      .arp_count (arp_count)
   );

   // Counter values as they stand in the trigger cycle, before its updates.
   always_comb begin
      meta_snap = '0;
      meta_snap[META_ARP_LSB    +: AZ_W]     = arp_count;
      meta_snap[META_ACP_LSB    +: AZ_W]     = acp_count;
      meta_snap[META_TICK_LSB   +: TICK_W]   = tick_q;
      meta_snap[META_TRIG_LSB   +: TRIG_W]   = trig_cnt_q;
      meta_snap[META_MISSED_LSB +: MISSED_W] = missed_q;
   end

   always_comb begin
      trig_edge   = trigger & ~trig_prev_q;
      accept      = trig_edge & run & (state_q == ST_IDLE);
      trig_prev_d = trigger;
      tick_d      = tick_q + TICK_W'(1);
      state_d     = state_q;
      cnt_d       = cnt_q;
      pre_d       = pre_q;
      eff_d       = eff_q;
      meta_d      = meta_q;
      trig_cnt_d  = trig_cnt_q;
      missed_d    = missed_q;

      // A trigger while a pulse is in flight is dropped, never queued.
      if (trig_edge && run && (state_q != ST_IDLE) && (missed_q != MISSED_MAX)) begin
         missed_d = missed_q + MISSED_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               meta_d     = meta_snap;
               pre_d      = pre_delay;
               eff_d      = (n_samples > META_WORDS_C) ? n_samples : META_WORDS_C;
               trig_cnt_d = trig_cnt_q + TRIG_W'(1);
               state_d    = ST_ARM;
            end
         end
         ST_ARM: begin
            if (pre_q == '0) begin
               cnt_d   = eff_q;
               state_d = ST_CAPTURE;
            end else begin
               cnt_d   = pre_q;
               state_d = ST_DELAY;
            end
         end
         ST_DELAY: begin
            if (strobe_in) begin
               if (cnt_q == CNT_ONE) begin
                  cnt_d   = eff_q;
                  state_d = ST_CAPTURE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         ST_CAPTURE: begin
            if (strobe_in) begin
               if (cnt_q == CNT_ONE) begin
                  cnt_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         trig_prev_q <= 1'b0;
         tick_q      <= '0;
         trig_cnt_q  <= '0;
         missed_q    <= '0;
         cnt_q       <= '0;
         pre_q       <= '0;
         eff_q       <= '0;
         meta_q      <= '0;
      end else begin
         state_q     <= state_d;
         trig_prev_q <= trig_prev_d;
         tick_q      <= tick_d;
         trig_cnt_q  <= trig_cnt_d;
         missed_q    <= missed_d;
         cnt_q       <= cnt_d;
         pre_q       <= pre_d;
         eff_q       <= eff_d;
         meta_q      <= meta_d;
      end
   end

   assign meta_data   = meta_q;
   assign pack_init   = (state_q == ST_ARM);
   assign pack_enable = (state_q == ST_CAPTURE);
   assign busy        = (state_q != ST_IDLE);
   assign pulse_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_pulse_capture_sequencer.sv
// Scoreboard bench for pulse_capture_sequencer: a strobe-budget reference model
// predicts each pulse; a negedge monitor checks what the packer interface shows.
module tb_pulse_capture_sequencer;

   localparam int META_WORDS = (112 + 4 - 1) / 4;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         run = 1'b0;
   logic         trigger = 1'b0;
   logic         acp = 1'b0;
   logic         arp = 1'b0;
   logic         strobe_in = 1'b0;
   logic [15:0]  pre_delay = '0;
   logic [15:0]  n_samples = '0;
   logic [111:0] meta_data;
   logic         pack_init;
   logic         pack_enable;
   logic         busy;
   logic         pulse_done;

   always #5 clock = ~clock;

   pulse_capture_sequencer dut (
      .clock       (clock),
      .reset       (reset),
      .run         (run),
      .trigger     (trigger),
      .acp         (acp),
      .arp         (arp),
      .strobe_in   (strobe_in),
      .pre_delay   (pre_delay),
      .n_samples   (n_samples),
      .meta_data   (meta_data),
      .pack_init   (pack_init),
      .pack_enable (pack_enable),
      .busy        (busy),
      .pulse_done  (pulse_done)
   );

   typedef struct {
      logic [111:0] meta;
      int           pre;
      int           eff;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // staged configuration, applied together with the next cycle's inputs
   logic        cfg_reset = 1'b0;
   logic        cfg_run = 1'b0;
   logic [15:0] cfg_pre = '0;
   logic [15:0] cfg_n = '0;
   int          trig_at[$];

   // reference model: free-running counters plus a remaining-strobe budget
   logic [31:0] m_tick, m_trig;
   logic [15:0] m_acp, m_arp, m_missed;
   logic        p_trig, p_acp, p_arp;
   bit          m_arm, m_done;
   int          m_left, m_pre, m_eff;
   bit          exp_busy = 0, exp_init = 0, exp_en = 0, exp_done = 0;

   task automatic chk(input string name, input logic [111:0] act, input logic [111:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_tick = '0; m_trig = '0; m_acp = '0; m_arp = '0; m_missed = '0;
      p_trig = 1'b0; p_acp = 1'b0; p_arp = 1'b0;
      m_arm = 0; m_done = 0; m_left = 0; m_pre = 0; m_eff = 0;
      exp_busy = 0; exp_init = 0; exp_en = 0; exp_done = 0;
      exp_q.delete();
   endtask

   task automatic model_eval();
      logic te, ae, re;
      int   n_left;
      bit   n_arm, n_done;
      exp_t e;
      te = trigger & ~p_trig;
      ae = acp & ~p_acp;
      re = arp & ~p_arp;
      exp_busy = m_arm || (m_left > 0) || m_done;
      exp_init = m_arm;
      exp_en   = !m_arm && (m_left > 0) && (m_left <= m_eff);
      exp_done = m_done;
      n_arm  = 0;
      n_done = 0;
      n_left = m_left;
      if (m_arm) n_left = m_pre + m_eff;
      else if ((m_left > 0) && strobe_in) begin
         n_left = m_left - 1;
         if (n_left == 0) n_done = 1;
      end
      if (te && run) begin
         if (exp_busy) begin
            if (m_missed != 16'hFFFF) m_missed = m_missed + 16'd1;
         end else begin
            m_pre  = int'(pre_delay);
            m_eff  = (int'(n_samples) > META_WORDS) ? int'(n_samples) : META_WORDS;
            e.meta = {m_missed, m_trig, m_tick, m_acp, m_arp};
            e.pre  = m_pre;
            e.eff  = m_eff;
            exp_q.push_back(e);
            m_trig = m_trig + 32'd1;
            n_arm  = 1;
         end
      end
      m_tick = m_tick + 32'd1;
      if (re) begin
         m_arp = m_arp + 16'd1;
         m_acp = '0;
      end else if (ae) begin
         m_acp = m_acp + 16'd1;
      end
      p_trig = trigger; p_acp = acp; p_arp = arp;
      m_arm = n_arm; m_left = n_left; m_done = n_done;
   endtask

   task automatic cyc(input logic t, input logic a, input logic r, input logic s);
      @(posedge clock);
      #1;
      reset = cfg_reset; run = cfg_run; pre_delay = cfg_pre; n_samples = cfg_n;
      trigger = t; acp = a; arp = r; strobe_in = s;
      if (cfg_reset) model_reset();
      else model_eval();
   endtask

   task automatic run_for(input int n, input int period);
      logic t;
      for (int i = 0; i < n; i++) begin
         t = 1'b0;
         foreach (trig_at[k]) if ((i >= trig_at[k]) && (i < trig_at[k] + 2)) t = 1'b1;
         cyc(t, 1'b0, 1'b0, (i % period) == (period - 1));
      end
   endtask

   task automatic do_reset();
      cfg_reset = 1'b1;
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cfg_reset = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // monitor state
   int           mcyc = 0, pulses = 0, mon_skip = 0, mon_en = 0, mon_last_en = 0;
   bit           mon_active = 0, mon_arm = 0;
   exp_t         mon_cur;
   logic [111:0] last_meta = '0;

   task automatic drain();
      trig_at.delete();
      for (int i = 0; (i < 3000) && (exp_busy || (exp_q.size() > 0) || mon_active); i++)
         cyc(1'b0, 1'b0, 1'b0, (i % 2) == 1);
      chk("drain_idle", 112'(busy), 112'(0));
      chk("drain_queue", 112'(exp_q.size()), 112'(0));
   endtask

   always @(negedge clock) begin
      if (reset) begin
         mon_active = 0;
         mon_arm    = 0;
      end else begin
         chk("busy", 112'(busy), 112'(exp_busy));
         chk("pack_init", 112'(pack_init), 112'(exp_init));
         chk("pack_enable", 112'(pack_enable), 112'(exp_en));
         chk("pulse_done", 112'(pulse_done), 112'(exp_done));
         if (pack_init) begin
            chk("init_has_expect", 112'(exp_q.size() > 0), 112'(1));
            if (exp_q.size() > 0) begin
               mon_cur = exp_q.pop_front();
               chk("meta_data", meta_data, mon_cur.meta);
               last_meta   = meta_data;
               pulses++;
               mon_active  = 1;
               mon_arm     = 1;
               mon_skip    = 0;
               mon_en      = 0;
               mon_last_en = -10;
            end
         end else if (mon_active) begin
            if (mon_arm) begin
               chk("direct_capture", 112'(pack_enable), 112'(mon_cur.pre == 0));
               mon_arm = 0;
            end
            if (pulse_done) begin
               chk("skipped_strobes", 112'(mon_skip), 112'(mon_cur.pre));
               chk("enabled_strobes", 112'(mon_en), 112'(mon_cur.eff));
               chk("done_latency", 112'(mcyc - mon_last_en), 112'(1));
               mon_active = 0;
            end else if (strobe_in) begin
               if (pack_enable) begin
                  mon_en++;
                  mon_last_en = mcyc;
               end else begin
                  mon_skip++;
               end
            end
         end
         mcyc++;
      end
   end

   initial begin
      int  p0;
      bit  tl, al, rl;
      model_reset();
      do_reset();
      chk("reset_meta", meta_data, 112'(0));
      chk("reset_busy", 112'(busy), 112'(0));

      // T1: pre_delay 3, 100 samples, strobe every 4 clocks (one lands in ARM)
      cfg_run = 1'b1; cfg_pre = 16'd3; cfg_n = 16'd100;
      p0 = pulses;
      trig_at = '{2};
      run_for(450, 4);
      chk("t1_pulses", 112'(pulses - p0), 112'(1));
      chk("t1_trig_count", 112'(last_meta[95:64]), 112'(0));

      // T2: short n_samples is raised to the metadata word count, no delay
      cfg_pre = 16'd0; cfg_n = 16'd5;
      p0 = pulses;
      run_for(160, 4);
      chk("t2_pulses", 112'(pulses - p0), 112'(1));

      // T3: second trigger mid-capture is missed, third after DONE is accepted
      do_reset();
      cfg_pre = 16'd2; cfg_n = 16'd30;
      p0 = pulses;
      trig_at = '{2, 30, 90};
      run_for(170, 2);
      chk("t3_pulses", 112'(pulses - p0), 112'(2));
      chk("t3_missed", 112'(last_meta[111:96]), 112'(1));
      chk("t3_trig_count", 112'(last_meta[95:64]), 112'(1));

      // T4: 10 acp, coincident acp+arp, 2 acp, then trigger
      cfg_pre = 16'd0; cfg_n = 16'd0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      trig_at.delete();
      run_for(150, 4);
      chk("t4_acp_count", 112'(last_meta[31:16]), 112'(2));
      chk("t4_arp_count", 112'(last_meta[15:0]), 112'(1));

      // T5: asynchronous reset in the middle of CAPTURE
      cfg_pre = 16'd1; cfg_n = 16'd50;
      trig_at = '{2};
      run_for(40, 2);
      @(negedge clock);
      chk("t5_enabled_before_reset", 112'(pack_enable), 112'(1));
      #2;
      reset = 1'b1;
      cfg_reset = 1'b1;
      model_reset();
      #1;
      chk("t5_async_enable", 112'(pack_enable), 112'(0));
      chk("t5_async_busy", 112'(busy), 112'(0));
      chk("t5_async_meta", meta_data, 112'(0));
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cfg_reset = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      p0 = pulses;
      run_for(160, 2);
      chk("t5_pulses", 112'(pulses - p0), 112'(1));
      chk("t5_trig_count", 112'(last_meta[95:64]), 112'(0));

      // T6: randomized levels, strobes and configuration
      tl = 0; al = 0; rl = 0;
      for (int i = 0; i < 4000; i++) begin
         if ((i % 200) == 0) begin
            cfg_run = ($urandom_range(0, 7) != 0);
            cfg_pre = 16'($urandom_range(0, 6));
            cfg_n   = 16'($urandom_range(0, 40));
         end
         if ($urandom_range(0, 9) == 0) tl = ~tl;
         if ($urandom_range(0, 3) == 0) al = ~al;
         if ($urandom_range(0, 39) == 0) rl = ~rl;
         cyc(tl, al, rl, $urandom_range(0, 1) == 1);
      end
      drain();

      // T7: missed counter saturation (counter preloaded near the top)
      cfg_run = 1'b1; cfg_pre = 16'd200; cfg_n = 16'd28;
      trig_at = '{2};
      run_for(10, 4);
      force dut.missed_q = 16'hFFF8;
      m_missed = 16'hFFF8;
      #1;
      release dut.missed_q;
      trig_at.delete();
      for (int k = 0; k < 20; k++) trig_at.push_back(4 * k);
      run_for(80, 4);
      drain();
      p0 = pulses;
      trig_at = '{2};
      run_for(20, 4);
      drain();
      chk("t7_pulses", 112'(pulses - p0), 112'(1));
      chk("t7_missed_saturated", 112'(last_meta[111:96]), 112'(16'hFFFF));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
